// File: rtl/hs_responder.sv
// -----------------------------------------------------------------------------
// hs_responder
//
// Receives payload words from an asynchronous 4-phase initiator and queues
// them in a first-word-fall-through FIFO that a local consumer drains.
//
// The initiator holds data_i stable while req_i is high. Each complete
// handshake (req up, ack up, req down, ack down) writes exactly one word.
// When the FIFO is full, the acknowledge is withheld. This back-pressures the
// initiator until the consumer pops an entry.
//
// Ports
//   clk        in   single clock; all state updates on the rising edge
//   reset      in   asynchronous, active-low; low clears all state at once
//   req_i      in   4-phase request, asynchronous to clk
//   data_i     in   DATA_W payload, stable while req_i is high
//   ack_o      out  4-phase acknowledge, registered
//   rd_en_i    in   pop request from the local consumer
//   rd_data_o  out  head FIFO entry (first-word-fall-through)
//   empty_o    out  FIFO holds zero entries
//   full_o     out  FIFO holds DEPTH entries
//   count_o    out  current FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module hs_responder #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,   // power of two, 2..16
    parameter int SYNC_STAGES = 2    // 2..3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic                     ack_o,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        ACK  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // req_i synchronizer
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_s;

    // The synchronizer resets to 0. That value says nothing about the real
    // req_i level. prime_q fills with ones in lock-step with the
    // synchronizer. Once its top bit is set, req_s holds a genuine
    // post-reset sample of req_i.
    // Without this, ARM would accept the reset value as "req low". A req_i
    // held high across reset would then be captured a second time.
    logic [SYNC_STAGES-1:0] prime_q, prime_d;
    logic                   primed;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], req_i};
        prime_d = {prime_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign req_s  = sync_q[SYNC_STAGES-1];
    assign primed = prime_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   ack_q, ack_d;
    logic   wr_en;

    // NOTE: every signal assigned in this block gets a default first. A path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        wr_en   = 1'b0;
        unique case (state_q)
            ARM: begin
                ack_d = 1'b0;
                if (primed && !req_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                ack_d = 1'b0;
                // full_o is this cycle's value. A pop on this same edge
                // does not open a slot until the next cycle.
                if (req_s && !full_o) begin
                    wr_en   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                ack_d = 1'b1;
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = ARM;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              pop_en;

    assign pop_en = rd_en_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_en) begin
            mem_d[wr_ptr_q] = data_i;
            // DEPTH is a power of two, so the natural overflow of an AW-bit
            // pointer is the modulo-DEPTH wrap.
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({wr_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples its pre-edge value, regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= '0;
            prime_q  <= '0;
            state_q  <= ARM;
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: the storage array is cleared on reset. rd_data_o reads
            // mem_q combinationally, so this makes it read 0 after reset
            // rather than stale data.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sync_q   <= sync_d;
            prime_q  <= prime_d;
            state_q  <= state_d;
            ack_q    <= ack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ack_o     = ack_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));

endmodule

// File: doc/hs_responder.md
HS_RESPONDER -- requirements
Module: hs_responder

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits.
REQ-002 Parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-003 Parameter SYNC_STAGES, default 2, req_i synchronizer flops; 2..3.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-006 req_i  input  1  4-phase request from initiator; asynchronous to clk.
REQ-007 data_i  input  DATA_W  payload; stable whenever req_i is high.
REQ-008 ack_o  output  1  4-phase acknowledge to initiator; registered.
REQ-009 rd_en_i  input  1  pop request from local consumer.
REQ-010 rd_data_o  output  DATA_W  head FIFO entry, first-word-fall-through.
REQ-011 empty_o  output  1  FIFO holds zero entries.
REQ-012 full_o  output  1  FIFO holds DEPTH entries.
REQ-013 count_o  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 req_s SHALL be req_i passed through SYNC_STAGES flops clocked by clk; the FSM SHALL use only req_s, never req_i.
REQ-015 FSM states SHALL be ARM, IDLE, ACK.
REQ-016 ARM: ack_o=0; on req_s==0 go to IDLE next cycle; else stay in ARM.
REQ-017 IDLE: ack_o=0; if req_s==1 and full_o==0, write data_i into FIFO this cycle, set ack_o=1 and go to ACK next cycle.
REQ-018 IDLE with req_s==1 and full_o==1: stay in IDLE, no write, ack_o held 0 (back-pressure) until a pop clears full_o.
REQ-019 ACK: ack_o=1; on req_s==0, clear ack_o and go to IDLE next cycle; else stay in ACK.
REQ-020 Latency: req_i rise to ack_o rise SHALL be SYNC_STAGES+1 clk cycles (FIFO not full); req_i fall to ack_o fall SHALL be SYNC_STAGES+1 cycles.
REQ-021 Exactly one FIFO write SHALL occur per complete 4-phase handshake.
REQ-022 FIFO pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; count_o SHALL range 0..DEPTH.
REQ-023 rd_data_o SHALL equal mem[rd_ptr] combinationally; rd_en_i with empty_o==0 SHALL advance rd_ptr and decrement count_o next cycle.
REQ-024 rd_en_i with empty_o==1 SHALL be ignored; pointers, count_o and rd_data_o unchanged.
REQ-025 Simultaneous write and pop with FIFO non-empty and not full: count_o unchanged, both pointers advance.
REQ-026 Write eligibility SHALL use full_o of the current cycle; a same-cycle pop SHALL NOT enable a write into a full FIFO.
REQ-027 empty_o SHALL equal (count_o==0); full_o SHALL equal (count_o==DEPTH).

Reset
REQ-028 While reset is low: ack_o=0, count_o=0, empty_o=1, full_o=0, pointers=0, memory=0 (rd_data_o=0), synchronizer flops=0, state=ARM.
REQ-029 Reset mid-handshake SHALL drop ack_o within the same cycle and discard all stored entries.
REQ-030 After reset deasserts, no capture SHALL occur until req_s has been observed low (ARM), so a stale high req_i is never captured twice.

Verification
REQ-031 Single transfer, SYNC_STAGES=2: data_i=0xA5, raise req_i -> ack_o high 3 cycles later; count_o=1; rd_data_o=0xA5; drop req_i -> ack_o low 3 cycles later.
REQ-032 Fill: 4 handshakes 0x01..0x04, no reads -> full_o=1, count_o=4; 5th req_i high -> ack_o stays 0; one rd_en_i pop -> ack_o rises 1 cycle after full_o clears; count_o returns to 4.
REQ-033 Wrap: 6 writes interleaved with 6 pops, DEPTH=4 -> pop order 0x10..0x15 exact, empty_o=1 at end.
REQ-034 Simultaneous: count_o=2, write 0x33 and pop in same cycle -> count_o stays 2, popped value is the old head.
REQ-035 Reset in ACK with req_i held high -> ack_o=0 immediately, count_o=0; after release ack_o stays 0 until req_i falls and rises again, then one entry captured.
REQ-036 Pop on empty: rd_en_i=1 with count_o=0 for 3 cycles -> count_o=0, rd_data_o=0, empty_o=1 throughout.
